// File: rtl/ro_meter_ctrl_if.sv
// Control/result bus between the lab top level and the ring-oscillator meter.
// The abort signal exists only when RO_ABORT_EN is defined.
interface ro_meter_ctrl_if #(
   parameter int GATE_W = 16,
   parameter int CNT_W  = 16
);
   logic              start;
   logic [GATE_W-1:0] gate_len;
`ifdef RO_ABORT_EN
   logic              abort;
`endif
   logic              busy;
   logic              done;
   logic [CNT_W-1:0]  edge_count;
   logic              overflow;

`ifdef RO_ABORT_EN
   modport master (output start, gate_len, abort, input busy, done, edge_count, overflow);
   modport slave  (input start, gate_len, abort, output busy, done, edge_count, overflow);
`else
   modport master (output start, gate_len, input busy, done, edge_count, overflow);
   modport slave  (input start, gate_len, output busy, done, edge_count, overflow);
`endif
endinterface

// File: rtl/ro_meter_ctrl.sv
// Ring-oscillator meter: enable RO, settle, count synced Feedback rising edges over gate_len cycles, report (abort input: RO_ABORT_EN).
// done at T+SETTLE_CYCLES+gate_len+3 (T+1 when gate_len==0); start is ignored, not queued, outside IDLE.
module ro_meter_ctrl #(
   parameter int GATE_W        = 16,
   parameter int CNT_W         = 16,
   parameter int SETTLE_CYCLES = 4
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           ro_fb,
   output logic           ro_en,
   ro_meter_ctrl_if.slave bus
);
   localparam int TW = (GATE_W > $clog2(SETTLE_CYCLES + 1)) ? GATE_W : $clog2(SETTLE_CYCLES + 1);
   localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, ARM, GATE, DRAIN, DONE} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [TW-1:0]     tmr;
   logic [GATE_W-1:0] gate_q;
   logic [CNT_W-1:0]  work_cnt;
   logic              work_ovf;
   logic [CNT_W-1:0]  cnt_q;
   logic              ovf_q;
   logic              busy_q;
   logic              done_q;
   logic              s1;
   logic              s2;
   logic              s3;
   logic              fb_rise;

   assign fb_rise        = s2 & ~s3;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.edge_count = cnt_q;
   assign bus.overflow   = ovf_q;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = (bus.gate_len == '0) ? DONE : ARM;
         ARM:     if (tmr == SETTLE_LAST) state_nxt = GATE;
         GATE:    if (tmr == TW'(gate_q) - TW'(1)) state_nxt = DRAIN;
         DRAIN:   if (tmr == TW'(1)) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
`ifdef RO_ABORT_EN
      if (bus.abort && (state == ARM || state == GATE || state == DRAIN)) state_nxt = IDLE;
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         tmr      <= '0;
         gate_q   <= '0;
         work_cnt <= '0;
         work_ovf <= 1'b0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         ro_en    <= 1'b0;
         s1       <= 1'b0;
         s2       <= 1'b0;
         s3       <= 1'b0;
      end else begin
         state <= state_nxt;
         s1    <= ro_fb;
         s2    <= s1;
         s3    <= s2;
         // Timer restarts on every state change so each phase counts from zero.
         if (state_nxt != state) tmr <= '0;
         else if (state != IDLE) tmr <= tmr + TW'(1);

         if (state == IDLE && bus.start) begin
            gate_q   <= bus.gate_len;
            work_cnt <= '0;
            work_ovf <= 1'b0;
         end else if (state == GATE && fb_rise) begin
            if (work_cnt == '1) work_ovf <= 1'b1;
            else work_cnt <= work_cnt + CNT_W'(1);
         end

         ro_en  <= (state_nxt == ARM) || (state_nxt == GATE);
         busy_q <= (state_nxt == ARM) || (state_nxt == GATE) || (state_nxt == DRAIN);
         done_q <= (state_nxt == DONE);
         // Zero-length gate goes straight from IDLE to DONE before the working regs clear.
         if (state_nxt == DONE) begin
            cnt_q <= (state == IDLE) ? '0 : work_cnt;
            ovf_q <= (state == IDLE) ? 1'b0 : work_ovf;
         end
      end
   end
endmodule

// File: tb/tb_ro_meter_ctrl.sv
// Bench for ro_meter_ctrl: timeline/edge-history reference model checked every cycle plus directed literal checks.
module tb_ro_meter_ctrl;
   localparam int GATE_W = 16;
   localparam int CNT_W  = 4;
   localparam int S      = 4;
   localparam int CMAX   = (1 << CNT_W) - 1;
   localparam int HMAX   = 16384;

   logic clk = 1'b0;
   logic reset;
   logic ro_fb;
   logic ro_en;
   logic abort_drv;
   logic fb_rand;
   int   cyc   = 0;
   int   n_vec = 0;
   int   n_err = 0;
   int   ph    = 0;
   bit   hist [HMAX];

   ro_meter_ctrl_if #(.GATE_W(GATE_W), .CNT_W(CNT_W)) bus ();
`ifdef RO_ABORT_EN
   assign bus.abort = abort_drv;
`endif

   ro_meter_ctrl #(.GATE_W(GATE_W), .CNT_W(CNT_W), .SETTLE_CYCLES(S)) dut (
      .clk(clk), .reset(reset), .ro_fb(ro_fb), .ro_en(ro_en), .bus(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %0d, want %0d", name, cyc, act, exp);
      end
   endtask

   // Oscillator stand-in: 5 high / 5 low while enabled, or free random toggling.
   initial begin
      ro_fb = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (fb_rand) begin
            if ($urandom_range(0, 2) == 0) ro_fb = ~ro_fb;
         end else if (ro_en) begin
            ro_fb = (ph < 5);
            ph = (ph + 1) % 10;
         end else begin
            ro_fb = 1'b0;
            ph = 0;
         end
      end
   end

   // Reference model: a run accepted in cycle t0 has a fixed timeline; the result
   // is the number of synced rising edges seen inside the gate window, saturated.
   bit m_on  = 1'b0;
   bit m_act = 1'b0;
   bit m_ovf = 1'b0;
   int m_t0  = 0;
   int m_glen = 0;
   int m_cnt = 0;

   function automatic int m_end();
      return (m_glen == 0) ? m_t0 + 1 : m_t0 + S + m_glen + 3;
   endfunction

   function automatic void tally();
      int edges = 0;
      for (int k = m_t0 + S + 1; k <= m_t0 + S + m_glen; k++)
         if (hist[k-2] && !hist[k-3]) edges++;
      m_cnt = (edges > CMAX) ? CMAX : edges;
      m_ovf = (edges > CMAX);
   endfunction

   always @(negedge clk) begin : model
      int c;
      int d;
      bit e_en;
      bit e_busy;
      bit e_done;
      c = cyc;
      e_en = 1'b0; e_busy = 1'b0; e_done = 1'b0;
      if (m_act) begin
         d = m_end();
         if (m_glen != 0) begin
            e_en   = (c > m_t0) && (c <= m_t0 + S + m_glen);
            e_busy = (c > m_t0) && (c < d);
         end
         if (c == d) begin
            e_done = 1'b1;
            tally();
         end
      end
      if (m_on) begin
         chk("ro_en", 32'(ro_en), 32'(e_en));
         chk("busy", 32'(bus.busy), 32'(e_busy));
         chk("done", 32'(bus.done), 32'(e_done));
         chk("edge_count", 32'(bus.edge_count), m_cnt);
         chk("overflow", 32'(bus.overflow), 32'(m_ovf));
      end
      if (reset) begin
         m_on = 1'b1; m_act = 1'b0; m_cnt = 0; m_ovf = 1'b0;
         hist[c] = 1'b0;
         if (c >= 1) hist[c-1] = 1'b0;
         if (c >= 2) hist[c-2] = 1'b0;
      end else begin
         hist[c] = ro_fb;
         if (m_act && abort_drv && c > m_t0 && c < m_end()) m_act = 1'b0;
         else if (m_act && c == m_end()) m_act = 1'b0;
         else if (!m_act && bus.start) begin
            m_act = 1'b1; m_t0 = c; m_glen = int'(bus.gate_len);
         end
      end
   end

   task automatic measure(input int glen, input bit pester, output int t, output int ef, output int el,
                          output int nd, output int dc, output int rc, output int rov);
      @(posedge clk); #1;
      bus.start = 1'b1; bus.gate_len = GATE_W'(glen); t = cyc;
      ef = -1; el = -1; nd = 0; dc = -1; rc = -1; rov = -1;
      for (int i = 1; i <= glen + S + 12; i++) begin
         @(posedge clk); #1;
         if (pester && cyc <= t + S + glen) begin
            bus.start = 1'($urandom_range(0, 1));
            bus.gate_len = GATE_W'($urandom);
         end else bus.start = 1'b0;
         @(negedge clk);
         if (ro_en) begin
            if (ef < 0) ef = cyc;
            el = cyc;
         end
         if (bus.done) begin
            nd++; dc = cyc; rc = int'(bus.edge_count); rov = int'(bus.overflow);
         end
      end
   endtask

   task automatic kill_run(input bit use_abort, input int exp_cnt);
      int t;
      int nd;
      @(posedge clk); #1;
      bus.start = 1'b1; bus.gate_len = GATE_W'(100); t = cyc;
      @(posedge clk); #1;
      bus.start = 1'b0;
      while (cyc < t + S + 50) begin
         @(posedge clk); #1;
      end
      if (use_abort) abort_drv = 1'b1;
      else reset = 1'b1;
      @(posedge clk); #1;
      abort_drv = 1'b0; reset = 1'b0;
      @(negedge clk);
      chk("kill_ro_en", 32'(ro_en), 0);
      chk("kill_busy", 32'(bus.busy), 0);
      chk("kill_edge_count", 32'(bus.edge_count), exp_cnt);
      nd = 0;
      repeat (150) begin
         @(negedge clk);
         if (bus.done) nd++;
      end
      chk("kill_no_done", nd, 0);
   endtask

   initial begin
      int t, ef, el, nd, dc, rc, rov;
      reset = 1'b1; bus.start = 1'b0; bus.gate_len = '0; abort_drv = 1'b0; fb_rand = 1'b0;
      @(negedge clk);
      chk("rst_ro_en", 32'(ro_en), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_done", 32'(bus.done), 0);
      chk("rst_edge_count", 32'(bus.edge_count), 0);
      chk("rst_overflow", 32'(bus.overflow), 0);
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      measure(0, 1'b0, t, ef, el, nd, dc, rc, rov);
      chk("zero_done_cycle", dc, t + 1);
      chk("zero_ro_en_never", ef, -1);
      chk("zero_count", rc, 0);
      chk("zero_ndone", nd, 1);

      measure(100, 1'b0, t, ef, el, nd, dc, rc, rov);
      chk("nom_en_first", ef, t + 1);
      chk("nom_en_last", el, t + 104);
      chk("nom_done_cycle", dc, t + 107);
      chk("nom_count", rc, 10);
      chk("nom_overflow", rov, 0);

      measure(200, 1'b0, t, ef, el, nd, dc, rc, rov);
      chk("sat_done_cycle", dc, t + 207);
      chk("sat_count", rc, 15);
      chk("sat_overflow", rov, 1);

      measure(100, 1'b1, t, ef, el, nd, dc, rc, rov);
      chk("busy_ignore_ndone", nd, 1);
      chk("busy_ignore_done_cycle", dc, t + 107);
      chk("busy_ignore_count", rc, 10);

      kill_run(1'b0, 0);

`ifdef RO_ABORT_EN
      measure(100, 1'b0, t, ef, el, nd, dc, rc, rov);
      chk("pre_abort_count", rc, 10);
      kill_run(1'b1, 10);
      measure(100, 1'b0, t, ef, el, nd, dc, rc, rov);
      chk("post_abort_done_cycle", dc, t + 107);
      chk("post_abort_count", rc, 10);
`endif

      fb_rand = 1'b1;
      repeat (3000) begin
         @(posedge clk); #1;
         bus.start    = ($urandom_range(0, 3) == 0);
         bus.gate_len = GATE_W'($urandom_range(0, 40));
         reset        = ($urandom_range(0, 199) == 0);
`ifdef RO_ABORT_EN
         abort_drv    = ($urandom_range(0, 59) == 0);
`endif
      end

      @(posedge clk); #1;
      reset = 1'b0; abort_drv = 1'b0;
      bus.start = 1'b1; bus.gate_len = GATE_W'(30);
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (10) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("midrst_ro_en", 32'(ro_en), 0);
      chk("midrst_busy", 32'(bus.busy), 0);
      chk("midrst_done", 32'(bus.done), 0);
      chk("midrst_edge_count", 32'(bus.edge_count), 0);
      chk("midrst_overflow", 32'(bus.overflow), 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      repeat (10) @(posedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
